match_mem_reader: RTL
=====================

# match_mem_reader

Drains committed match records from the sniffer's match memory and streams them to the host-side readout port. The match-capture path writes each matched packet as one record (header word + payload words) and advances a committed write pointer. This block is the consuming end of that memory: it reads records in order, frames them as sop/eop beats on a valid/ready stream, and returns its read pointer so the writer can see freed space.

## Interface
Parameters:
- ADDR_W, 8, match memory address width; pointers wrap modulo 2^ADDR_W
- DATA_W, 32, memory word / stream beat width
- LEN_W, 8, header length field width (bits [LEN_W-1:0] of header word); LEN_W ≤ ADDR_W

Ports (clock, then reset; one clock, reset asynchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- wr_ptr  in  ADDR_W  writer's committed pointer (one past last complete record)
- flush  in  1  synchronous abort; discard all unread records
- mem_rden  out  1  memory read enable
- mem_rdaddr  out  ADDR_W  memory read address
- mem_rddata  in  DATA_W  read data, valid exactly 1 cycle after mem_rden
- out_data  out  DATA_W  stream beat
- out_valid  out  1  beat valid
- out_sop  out  1  first beat of record (header)
- out_eop  out  1  last beat of record
- out_ready  in  1  host accepts beat when out_valid & out_ready
- rd_ptr  out  ADDR_W  next unread address, returned to writer
- busy  out  1  state ≠ IDLE
- rec_done  out  1  one-cycle pulse: record's eop beat accepted
- err_len  out  1  one-cycle pulse: header length inconsistent with stored data

## Operation
- avail = (wr_ptr − rd_ptr) mod 2^ADDR_W; empty when avail = 0. Writer never fills the last slot, so avail = 0 always means empty.
- Record = header word (LEN in [LEN_W-1:0]) + LEN payload words; total LEN+1 words. LEN = 0 is legal: header beat carries sop and eop.
- States:
  - IDLE: if !empty & !flush → RD_HDR.
  - RD_HDR: mem_rden=1, mem_rdaddr=rd_ptr → CHK_HDR.
  - CHK_HDR: capture LEN from mem_rddata. If LEN+1 > avail (compared in ADDR_W+1 bits): pulse err_len, rd_ptr←wr_ptr, → IDLE. Else load output register with header, out_sop=1, out_eop=(LEN==0), out_valid=1, rd_ptr+1, remaining←LEN → PRESENT.
  - PRESENT: hold data/sop/eop/valid stable until out_ready. On accept: if eop, pulse rec_done → IDLE; else out_valid=0 → RD_DATA.
  - RD_DATA: mem_rden=1, mem_rdaddr=rd_ptr → WAIT_DATA.
  - WAIT_DATA: load mem_rddata, sop=0, eop=(remaining==1), out_valid=1, rd_ptr+1, remaining−1 → PRESENT.
- flush in any state: next cycle state=IDLE, out_valid=0, rd_ptr←wr_ptr; no eop or rec_done emitted for an aborted record. flush beats err_len in the same cycle (err_len not pulsed).
- wr_ptr may advance at any time; avail is sampled in CHK_HDR only.
- rd_ptr and mem_rdaddr wrap from 2^ADDR_W−1 to 0 silently; records may straddle the wrap.

## Timing
- Reset values: state IDLE, rd_ptr 0, out_valid/out_sop/out_eop 0, out_data 0, mem_rden 0, mem_rdaddr 0, busy 0, rec_done 0, err_len 0.
- All outputs registered; none combinational from out_ready.
- Header latency: !empty seen in IDLE at cycle t → mem_rden at t+1 → out_valid at t+3.
- Payload throughput with out_ready held high: one beat per 3 cycles (PRESENT, RD_DATA, WAIT_DATA).
- rd_ptr advances in the cycle each word is loaded into the output register, not on host accept.
- rec_done asserts the cycle after the eop accept edge, for one cycle.
- Mid-operation rst: all state cleared immediately; partial record lost.

## Structure
- sniffer_pkg: reader state enum (IDLE, RD_HDR, CHK_HDR, PRESENT, RD_DATA, WAIT_DATA), header LEN field LSB/width constants shared with the match-capture writer.
- Single module, no sub-module; output beat register inline.

## Test plan
- Reset, wr_ptr=0 → stays IDLE, all outputs 0, no mem_rden.
- Record at 0: header LEN=2, payload 0xA1,0xA2; wr_ptr=3, out_ready=1 → beats HDR(sop), 0xA1, 0xA2(eop); rec_done once; rd_ptr=3; header out_valid 3 cycles after wr_ptr update.
- LEN=0 header at 5, wr_ptr=6 → single beat sop=eop=1, rd_ptr=6.
- Record at 0xFE, LEN=3, wr_ptr=0x02, out_ready toggling 1/0 → beats from addresses FE,FF,00,01; data stable while out_ready=0; rd_ptr=0x02.
- Header LEN=9 with wr_ptr−rd_ptr=4 → err_len pulse, no out_valid, rd_ptr=wr_ptr, IDLE.
- flush asserted during second payload beat of LEN=4 record → out_valid 0 next cycle, no eop, no rec_done, rd_ptr=wr_ptr.

Source files
------------

// File: rtl/match_mem_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_mem_reader_pkg                                                 |
// | Reader state encoding and header field layout shared with the        |
// | match-capture writer.                                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package match_mem_reader_pkg;

  // Reader FSM state encoding
  localparam int c_st_w = 3;
  typedef logic [c_st_w-1:0] rd_state_t;

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_rd_hdr    = 3'd1;
  localparam logic [2:0] c_st_chk_hdr   = 3'd2;
  localparam logic [2:0] c_st_present   = 3'd3;
  localparam logic [2:0] c_st_rd_data   = 3'd4;
  localparam logic [2:0] c_st_wait_data = 3'd5;

  // Header word layout: LEN field starts at bit 0; its width is LEN_W
  localparam int c_len_lsb = 0;

endpackage
`default_nettype wire

// File: rtl/match_mem_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_mem_reader_if                                                  |
// | Match-memory read port plus framed readout stream.                   |
// | master = reader side, slave = memory/host side.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface match_mem_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  import match_mem_reader_pkg::*;

  logic              mem_rden;
  logic [ADDR_W-1:0] mem_rdaddr;
  logic [DATA_W-1:0] mem_rddata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic              out_ready;

  modport master (
    output mem_rden, mem_rdaddr, out_data, out_valid, out_sop, out_eop,
    input  mem_rddata, out_ready
  );

  modport slave (
    input  mem_rden, mem_rdaddr, out_data, out_valid, out_sop, out_eop,
    output mem_rddata, out_ready
  );

endinterface
`default_nettype wire

// File: rtl/match_mem_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | match_mem_reader                                                     |
// | Drains committed match records (header + LEN payload words) from the |
// | match memory and streams them as sop/eop-framed valid/ready beats.   |
// | Returns its read pointer so the writer can reclaim space.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module match_mem_reader
  import match_mem_reader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [ADDR_W-1:0] wr_ptr,
  input  wire logic              flush,
  match_mem_reader_if.master     bus,
  output logic [ADDR_W-1:0]      rd_ptr,
  output logic                   busy,
  output logic                   rec_done,
  output logic                   err_len
);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic              r_busy;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_sop;
  logic              r_out_eop;
  logic              r_mem_rden;
  logic [ADDR_W-1:0] r_mem_rdaddr;
  logic              r_rec_done;
  logic              r_err_len;

  logic [ADDR_W-1:0] w_avail;
  logic              w_empty;
  logic [LEN_W-1:0]  w_len;
  logic [ADDR_W:0]   w_need;
  logic              w_len_bad;
  logic              w_accept;

  // Occupancy is a modular difference; the writer never fills the last
  // slot, so zero is unambiguously empty.
  assign w_avail   = wr_ptr - r_rd_ptr;
  assign w_empty   = (w_avail == '0);
  assign w_len     = bus.mem_rddata[c_len_lsb +: LEN_W];
  // Compare with one extra bit so LEN = 2^LEN_W-1 cannot wrap LEN+1 to 0
  assign w_need    = (ADDR_W+1)'(w_len) + (ADDR_W+1)'(1);
  assign w_len_bad = (w_need > {1'b0, w_avail});
  assign w_accept  = r_out_valid && bus.out_ready;

  // Next-state selection; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:      if (!w_empty) w_state_nxt = c_st_rd_hdr;
        c_st_rd_hdr:    w_state_nxt = c_st_chk_hdr;
        c_st_chk_hdr:   w_state_nxt = w_len_bad ? c_st_idle : c_st_present;
        c_st_present:   if (w_accept) w_state_nxt = r_out_eop ? c_st_idle : c_st_rd_data;
        c_st_rd_data:   w_state_nxt = c_st_wait_data;
        c_st_wait_data: w_state_nxt = c_st_present;
        default:        w_state_nxt = c_st_idle;
      endcase
    end
  end

  // State register; busy is registered from the next state so it tracks r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != c_st_idle);
    end
  end

  // Datapath: read requests, output beat register, read pointer and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_remaining  <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_mem_rden   <= 1'b0;
      r_mem_rdaddr <= '0;
      r_rec_done   <= 1'b0;
      r_err_len    <= 1'b0;
    end else begin
      r_mem_rden <= 1'b0;
      r_rec_done <= 1'b0;
      r_err_len  <= 1'b0;
      if (flush) begin
        // Abort: drop the partial record silently and skip everything unread
        r_out_valid <= 1'b0;
        r_out_sop   <= 1'b0;
        r_out_eop   <= 1'b0;
        r_rd_ptr    <= wr_ptr;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (!w_empty) begin
              r_mem_rden   <= 1'b1;
              r_mem_rdaddr <= r_rd_ptr;
            end
          end
          c_st_chk_hdr: begin
            if (w_len_bad) begin
              // Header claims more words than were committed: resync to writer
              r_err_len <= 1'b1;
              r_rd_ptr  <= wr_ptr;
            end else begin
              r_out_data  <= bus.mem_rddata;
              r_out_sop   <= 1'b1;
              r_out_eop   <= (w_len == '0);
              r_out_valid <= 1'b1;
              r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
              r_remaining <= w_len;
            end
          end
          c_st_present: begin
            if (w_accept) begin
              r_out_valid <= 1'b0;
              r_out_sop   <= 1'b0;
              r_out_eop   <= 1'b0;
              if (r_out_eop) begin
                r_rec_done <= 1'b1;
              end else begin
                r_mem_rden   <= 1'b1;
                r_mem_rdaddr <= r_rd_ptr;
              end
            end
          end
          c_st_wait_data: begin
            r_out_data  <= bus.mem_rddata;
            r_out_sop   <= 1'b0;
            r_out_eop   <= (r_remaining == LEN_W'(1));
            r_out_valid <= 1'b1;
            r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_rden   = r_mem_rden;
  assign bus.mem_rdaddr = r_mem_rdaddr;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sop    = r_out_sop;
  assign bus.out_eop    = r_out_eop;
  assign rd_ptr         = r_rd_ptr;
  assign busy           = r_busy;
  assign rec_done       = r_rec_done;
  assign err_len        = r_err_len;

endmodule
`default_nettype wire
